// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame link (transmitter and receiver).
// Frame format: idle-high line, start bit, port address (MSB first),
// data-bit count (MSB first), payload (LSB first), optional parity bit.
package serial_frame_pkg;

  localparam int   PORT_W_DEF = 2;
  localparam int   CNT_W_DEF  = 4;
  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PORT,
    S_COUNT,
    S_DATA,
    S_PARITY,
    S_DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/status bundle between a frame producer (master) and the
// serial frame transmitter (slave).
interface serial_frame_tx_if #(
  parameter int PORT_W = 2,
  parameter int CNT_W  = 4,
  parameter int DATA_W = 15
) ();

  logic              start;
  logic [PORT_W-1:0] portNum;
  logic [CNT_W-1:0]  dataLen;
  logic [DATA_W-1:0] dataIn;
  logic              serOut;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (
    output start, portNum, dataLen, dataIn,
    input  serOut, ready, busy, done
  );

  modport slave (
    input  start, portNum, dataLen, dataIn,
    output serOut, ready, busy, done
  );

endinterface

// File: rtl/serial_frame_tx_field_shifter.sv
// serial_field_shifter: loadable LSB-first shift register with a bit
// down-counter. Reloaded once per frame field. It keeps only the bits still
// to come after the one being loaded/shifted out, and reports the bit that
// will be on the line next cycle so the caller can register it.
module serial_field_shifter #(
  parameter int W  = 15,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_val,
  input  logic [CW-1:0] i_load_cnt,
  input  logic          i_shift,
  output logic          o_next_bit,
  output logic          o_last
);

  logic [W-2:0]  r_sh;
  logic [CW-1:0] r_cnt;

  // Load a new field (load wins over shift), otherwise advance one bit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_load_val[W-1:1];
      r_cnt <= i_load_cnt;
    end else if (i_shift) begin
      r_sh  <= r_sh >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_next_bit = i_load ? i_load_val[0] : r_sh[0];
  assign o_last     = (r_cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serializes one request per frame onto an idle-high line.
// Optional feature macro: SERIAL_FRAME_PARITY_EN appends an even-parity bit
// over the sent payload bits after the data field.
// All outputs come straight from flops; no input reaches an output
// combinationally.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int PORT_W = PORT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = (1 << CNT_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_tx_if.slave  bus
);

  localparam int CTR_W = max_int(PORT_W, CNT_W);

`ifdef SERIAL_FRAME_PARITY_EN
  localparam state_e TAIL_STATE = S_PARITY;
`else
  localparam state_e TAIL_STATE = S_DONE;
`endif

  state_e            r_state, w_state_nxt;
  logic [PORT_W-1:0] r_port;
  logic [CNT_W-1:0]  r_len;
  logic [DATA_W-1:0] r_data;
  logic              r_ser_out, r_ready, r_busy, r_done;

  logic              w_accept;
  logic              w_load, w_shift, w_next_bit, w_last;
  logic [DATA_W-1:0] w_load_val;
  logic [CTR_W-1:0]  w_load_cnt;
  logic [PORT_W-1:0] w_port_rev;
  logic [CNT_W-1:0]  w_len_rev;
  logic              w_ser_nxt;
  logic              w_par_nxt;

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // Capture the request so later input changes cannot disturb the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_port <= '0;
      r_len  <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_port <= bus.portNum;
      r_len  <= bus.dataLen;
      r_data <= bus.dataIn;
    end
  end

  // Bit-reverse the MSB-first fields so the shifter can always send LSB first.
  always_comb begin
    w_port_rev = '0;
    w_len_rev  = '0;
    for (int i = 0; i < PORT_W; i++) w_port_rev[i] = r_port[PORT_W-1-i];
    for (int i = 0; i < CNT_W; i++)  w_len_rev[i]  = r_len[CNT_W-1-i];
  end

  serial_field_shifter #(
    .W  (DATA_W),
    .CW (CTR_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_load_cnt (w_load_cnt),
    .i_shift    (w_shift),
    .o_next_bit (w_next_bit),
    .o_last     (w_last)
  );

`ifdef SERIAL_FRAME_PARITY_EN
  logic r_par;

  // Running XOR of payload bits as they appear on the line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= 1'b0;
    end else if (r_state == S_DATA) begin
      r_par <= r_par ^ r_ser_out;
    end
  end

  assign w_par_nxt = (r_state == S_DATA) ? (r_par ^ r_ser_out) : r_par;
`else
  assign w_par_nxt = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and shifter control; each field is loaded on entry.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_val  = '0;
    w_load_cnt  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_START;
      end
      S_START: begin
        w_state_nxt = S_PORT;
        w_load      = 1'b1;
        w_load_val  = DATA_W'(w_port_rev);
        w_load_cnt  = CTR_W'(PORT_W - 1);
      end
      S_PORT: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_state_nxt = S_COUNT;
          w_load      = 1'b1;
          w_load_val  = DATA_W'(w_len_rev);
          w_load_cnt  = CTR_W'(CNT_W - 1);
        end
      end
      S_COUNT: begin
        w_shift = 1'b1;
        if (w_last) begin
          if (r_len != '0) begin
            w_state_nxt = S_DATA;
            w_load      = 1'b1;
            w_load_val  = r_data;
            w_load_cnt  = CTR_W'(r_len - CNT_W'(1));
          end else begin
            w_state_nxt = TAIL_STATE;
          end
        end
      end
      S_DATA: begin
        w_shift = 1'b1;
        if (w_last) w_state_nxt = TAIL_STATE;
      end
      S_PARITY: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Line level for the coming cycle, chosen by the state being entered.
  always_comb begin
    w_ser_nxt = IDLE_LEVEL;
    unique case (w_state_nxt)
      S_START:                  w_ser_nxt = START_BIT;
      S_PORT, S_COUNT, S_DATA:  w_ser_nxt = w_next_bit;
      S_PARITY:                 w_ser_nxt = w_par_nxt;
      default:                  w_ser_nxt = IDLE_LEVEL;
    endcase
  end

  // Registered line and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ser_out <= IDLE_LEVEL;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_ser_out <= w_ser_nxt;
      r_ready   <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.serOut = r_ser_out;
  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx. The reference model builds each
// expected frame as a bit queue straight from the frame format and checks the
// line and status outputs cycle by cycle. Honors SERIAL_FRAME_PARITY_EN.
module tb_serial_frame_tx;

  localparam int PORT_W = 2;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 15;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  serial_frame_tx_if #(.PORT_W(PORT_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  serial_frame_tx #(.PORT_W(PORT_W), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ser"},   32'(bus.serOut), 32'd1);
    check({tag, "_ready"}, 32'(bus.ready),  32'd1);
    check({tag, "_busy"},  32'(bus.busy),   32'd0);
    check({tag, "_done"},  32'(bus.done),   32'd0);
  endtask

  // Runs one frame starting at a negedge in an idle cycle. abort_at >= 0
  // pulls reset while frame bit abort_at is on the line.
  task automatic run_frame(input logic [1:0] p, input logic [3:0] n,
                           input logic [14:0] d, input bit hold, input int abort_at);
    bit          exp_q[$];
    logic [14:0] mask;
    exp_q.push_back(1'b0);
    for (int i = PORT_W - 1; i >= 0; i--) exp_q.push_back(p[i]);
    for (int i = CNT_W - 1; i >= 0; i--)  exp_q.push_back(n[i]);
    for (int i = 0; i < int'(n); i++)     exp_q.push_back(d[i]);
`ifdef SERIAL_FRAME_PARITY_EN
    mask = (15'd1 << n) - 15'd1;
    exp_q.push_back(^(d & mask));
`else
    mask = '0;
`endif
    check("ready_pre", 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.portNum = p;
    bus.dataLen = n;
    bus.dataIn  = d;
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (!hold) bus.start = 1'b0;
      bus.portNum = 2'($urandom);
      bus.dataLen = 4'($urandom);
      bus.dataIn  = 15'($urandom);
      check("ser",   32'(bus.serOut), 32'(exp_q[i]));
      check("busy",  32'(bus.busy),   32'd1);
      check("ready", 32'(bus.ready),  32'd0);
      check("done",  32'(bus.done),   32'd0);
      if (i == abort_at) begin
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_idle("abort_rst");
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_after");
        return;
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(bus.done),   32'd1);
    check("done_ser",   32'(bus.serOut), 32'd1);
    check("done_busy",  32'(bus.busy),   32'd0);
    check("done_ready", 32'(bus.ready),  32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check_idle("post");
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.portNum = '0;
    bus.dataLen = '0;
    bus.dataIn  = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_rel");

    // Directed frames: basic, empty payload, full payload with start held.
    run_frame(2'b10, 4'd3,  15'b101, 1'b0, -1);
    run_frame(2'b01, 4'd0,  15'h7fff, 1'b0, -1);
    run_frame(2'b11, 4'd15, 15'h5555, 1'b1, -1);
    // Still idle one cycle after a held-start frame: no second capture.
    @(negedge clk);
    check_idle("no_requeue");

    // Abort during data bit 2, then a full frame must follow cleanly.
    run_frame(2'b10, 4'd8, 15'h2d6b, 1'b0, 1 + PORT_W + CNT_W + 2);
    run_frame(2'b01, 4'd5, 15'h0013, 1'b0, -1);

    // Parity-relevant payloads (plain frames when parity is disabled).
    run_frame(2'b00, 4'd3, 15'b011, 1'b0, -1);
    run_frame(2'b00, 4'd3, 15'b111, 1'b0, -1);

    // Randomized frames, some with start held, some aborted.
    for (int k = 0; k < 30; k++) begin
      logic [3:0] n;
      int         ab;
      n  = 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6 + int'(n))) : -1;
      run_frame(2'($urandom), n, 15'($urandom), bit'($urandom_range(0, 1)), ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that produces the single-bit stream consumed by the team's serial port-demultiplexing receiver: an idle-high line, a start bit, a port address, a data-bit count, then the data bits. It accepts one parallel request per frame, serializes it one bit per clock, and reports busy and done status. It sits on the sending side of the serial link, driving the receiver's serial input directly and sharing its clock.

## Interface
- PORT_W, 2: port address width in bits.
- CNT_W, 4: data-bit count width in bits; max frame payload is 2**CNT_W-1 bits.
- DATA_W, 15: payload register width; must equal 2**CNT_W-1.

- clk  in  1  rising-edge clock, single domain.
- rst  in  1  reset; synchronous, active-low (0 = reset, sampled on clk rising edge).
- start  in  1  request strobe; accepted only in a cycle where ready=1.
- portNum  in  PORT_W  destination port, captured on accept.
- dataLen  in  CNT_W  number of payload bits N, captured on accept.
- dataIn  in  DATA_W  payload, captured on accept; dataIn[0] sent first, bits at index >= N ignored.
- serOut  out  1  serial line; 1 when idle.
- ready  out  1  1 when IDLE and a request can be accepted.
- busy  out  1  1 while a frame is on the line (START through last bit).
- done  out  1  one-cycle pulse after the last frame bit.

## Operation
- FSM states: IDLE, START, PORT, COUNT, DATA, PARITY (only with macro), DONE.
- IDLE: serOut=1, ready=1. On start=1: capture portNum/dataLen/dataIn into shadow registers, go START. start with ready=0 is ignored (no queueing).
- START: serOut=0 for one cycle -> PORT.
- PORT: PORT_W cycles, portNum MSB-first -> COUNT.
- COUNT: CNT_W cycles, dataLen MSB-first. Then DATA if N>0; if N=0, PARITY (macro on) or DONE.
- DATA: N cycles, shadow payload LSB-first via right shift -> PARITY or DONE.
- DONE: serOut=1, done=1, ready=0 for one cycle -> IDLE.
- Bit counter loaded on each state entry with field length minus 1, decremented per cycle; state advances when counter = 0. Counter width = max(PORT_W, CNT_W).
- Input changes after accept have no effect on the frame in flight.

## Timing
- Reset values: serOut=1, ready=1, busy=0, done=0, state IDLE, shadow registers 0.
- rst=0 mid-frame: at that edge the frame is abandoned; from the next cycle outputs equal reset values; no done pulse.
- Accept at edge k: start bit on serOut in cycle k+1.
- Frame length L = 1 + PORT_W + CNT_W + N (+1 with parity); busy=1 for exactly L cycles.
- done in cycle k+L+1; ready returns in cycle k+L+2. Minimum gap between frames: 2 idle-high cycles (DONE + IDLE accept cycle).
- serOut is registered; no combinational path from inputs to any output.

## Configuration
- SERIAL_FRAME_PARITY_EN defined: PARITY state appends one bit after the data field = XOR of the N sent payload bits (even parity over the payload; 0 when N=0). L grows by 1.
- Not defined: no PARITY state; COUNT/DATA go straight to DONE; frame format matches the base receiver exactly.

## Structure
- Package serial_frame_pkg: FSM state enum, default PORT_W/CNT_W, START_BIT=0, IDLE_LEVEL=1. The receiver imports the same package.
- Sub-module serial_field_shifter: loadable shift register with down-counter and last-bit flag, instantiated once and reloaded per field (port, count, data).

## Test plan
- Reset: hold rst=0 3 cycles -> serOut=1, ready=1, busy=0, done=0.
- portNum=2'b10, dataLen=4'd3, dataIn=...101, start pulse -> serOut sequence 0,1,0,0,0,1,1,1,0,1 then done one cycle later; busy exactly 10 cycles.
- dataLen=0, portNum=2'b01 -> serOut 0,0,1,0,0,0,0; no DATA cycles; done after 7 bits.
- dataLen=15, dataIn=15'h5555 -> 15 alternating bits starting 1; busy 22 cycles; start held high during frame causes no second capture until ready.
- rst=0 during DATA bit 2 -> serOut=1 from next cycle, no done; new request afterwards produces a full correct frame.
- With SERIAL_FRAME_PARITY_EN, dataLen=3, dataIn=3'b011 -> parity bit 0 after data; dataIn=3'b111 -> parity bit 1; L=11.
